mul_div_unit: RTL

- Multi-cycle signed multiply/divide unit sitting downstream of the datapath bus.
- Consumes operand A from the Y register and operand B from BusMuxOut.
- Produces a 64-bit result split into ZHigh/ZLow, which feeds BusMuxIn_Zhigh/BusMuxIn_Zlow (and, via the bus, HI/LO).
- Replaces single-cycle combinational MUL/DIV in the ALU path; the control sequencer holds the bus stable only for the start cycle.

---
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit.
// MUL uses radix-2 Booth; DIV uses restoring division on magnitudes with a sign fix-up.
// Fixed latency: start accepted at edge k gives a one-cycle done pulse after edge k+33.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] ZHigh,
   output logic [WIDTH-1:0] ZLow
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             op_q;
   logic [WIDTH-1:0] a_q;     // original A, needed for signs and the divide-by-zero result
   logic [WIDTH-1:0] b_q;     // original B, needed for signs and the zero check
   logic [WIDTH-1:0] m_q;     // MUL: multiplicand; DIV: |divisor|
   logic [WIDTH:0]   acc_q;   // one guard bit so Booth survives -(-2^(WIDTH-1))
   logic [WIDTH-1:0] q_q;     // MUL: multiplier/low product; DIV: dividend/quotient
   logic             qm1_q;
   logic             busy_q, done_q, dbz_q;
   logic [WIDTH-1:0] zhi_q, zlo_q;

   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   booth_sum, rem_sh, trial;
   logic [WIDTH:0]   acc_n;
   logic [WIDTH-1:0] q_n;
   logic             qm1_n;
   logic [WIDTH-1:0] zhi_fix, zlo_fix;
   logic             dbz_fix;

   // Operand magnitudes, one iteration step, and the final result assembly
   always_comb begin
      abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
      abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;

      unique case ({q_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
         2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
         default: booth_sum = acc_q;
      endcase

      rem_sh = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, m_q};

      if (!op_q) begin
         // Arithmetic shift right of {acc, Q, q-1}
         acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
         q_n   = {booth_sum[0], q_q[WIDTH-1:1]};
         qm1_n = q_q[0];
      end else if (!trial[WIDTH]) begin
         acc_n = trial;
         q_n   = {q_q[WIDTH-2:0], 1'b1};
         qm1_n = 1'b0;
      end else begin
         acc_n = rem_sh;
         q_n   = {q_q[WIDTH-2:0], 1'b0};
         qm1_n = 1'b0;
      end

      dbz_fix = 1'b0;
      if (!op_q) begin
         zhi_fix = acc_q[WIDTH-1:0];
         zlo_fix = q_q;
      end else if (b_q == '0) begin
         zhi_fix = a_q;
         zlo_fix = '1;
         dbz_fix = 1'b1;
      end else begin
         zlo_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~q_q + 1'b1) : q_q;
         zhi_fix = a_q[WIDTH-1] ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      end
   end

   // Control FSM with registered outputs and iteration datapath
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         zhi_q   <= '0;
         zlo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  op_q    <= op;
                  a_q     <= A;
                  b_q     <= B;
                  m_q     <= op ? abs_b : A;
                  q_q     <= op ? abs_a : B;
                  acc_q   <= '0;
                  qm1_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  dbz_q   <= 1'b0;
                  state_q <= StCalc;
               end else begin
                  state_q <= StIdle;
               end
            end
            StCalc: begin
               acc_q <= acc_n;
               q_q   <= q_n;
               qm1_q <= qm1_n;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_q <= StFix;
            end
            StFix: begin
               zhi_q   <= zhi_fix;
               zlo_q   <= zlo_fix;
               dbz_q   <= dbz_fix;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StDone;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign ZHigh       = zhi_q;
   assign ZLow        = zlo_q;

endmodule
